// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: owns the architectural PC,
// talks req/ready to a variable-latency instruction memory and feeds decode.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  output logic        imemReq,
  output logic [15:0] imemAddr,
  input  logic        imemReady,
  input  logic [15:0] imemData,
  output logic [15:0] instr,
  output logic [15:0] PC,
  output logic        valid,
  output logic        halted,
  output logic        err,
  output logic [2:0]  dbg_state
);

  // Memory handshake: imemReq is held with a stable imemAddr until a cycle in which
  // imemReady is high; that cycle's imemData is the response and the request is retired.
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_WAIT    = 3'd1,
    S_HOLD    = 3'd2,
    S_DISCARD = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_reg_q, pc_reg_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        valid_q, valid_d;
  logic [15:0] skid_q, skid_d;
  logic        err_q, err_d;
  logic        req_out;

  function automatic logic is_halt(input logic [15:0] ins);
    return ins[15:11] == 5'b00000;
  endfunction

  assign req_out = (state_q == S_FETCH) || (state_q == S_WAIT);

  always_comb begin
    state_d  = state_q;
    pc_reg_d = pc_reg_q;
    instr_d  = instr_q;
    if_pc_d  = if_pc_q;
    valid_d  = valid_q;
    skid_d   = skid_q;
    err_d    = err_q;
    if (redirect) begin
      pc_reg_d = redirectPC;
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      skid_d   = NOP_INSTR;
      err_d    = err_q | redirectPC[0];
      // A still-pending request must have its wrong-path response absorbed first.
      if ((req_out || state_q == S_DISCARD) && !imemReady) state_d = S_DISCARD;
      else state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH, S_WAIT: begin
          if (imemReady) begin
            pc_reg_d = pc_reg_q + 16'd2;
            if (stall) begin
              skid_d  = imemData;
              state_d = S_HOLD;
            end else begin
              instr_d = imemData;
              if_pc_d = pc_reg_q + 16'd2;
              valid_d = 1'b1;
              state_d = is_halt(imemData) ? S_HALTED : S_FETCH;
            end
          end else begin
            state_d = S_WAIT;
            if (!stall) begin
              instr_d = NOP_INSTR;
              valid_d = 1'b0;
            end
          end
        end
        S_HOLD: begin
          // pc_reg already advanced past the skid entry, so it is that entry's PC+2.
          if (!stall) begin
            instr_d = skid_q;
            if_pc_d = pc_reg_q;
            valid_d = 1'b1;
            state_d = is_halt(skid_q) ? S_HALTED : S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imemReady) state_d = S_FETCH;
          if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        S_HALTED: begin
          if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_reg_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      if_pc_q  <= 16'h0000;
      valid_q  <= 1'b0;
      skid_q   <= NOP_INSTR;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_reg_q <= pc_reg_d;
      instr_q  <= instr_d;
      if_pc_q  <= if_pc_d;
      valid_q  <= valid_d;
      skid_q   <= skid_d;
      err_q    <= err_d;
    end
  end

  assign imemReq   = req_out;
  assign imemAddr  = pc_reg_q;
  assign instr     = instr_q;
  assign PC        = if_pc_q;
  assign valid     = valid_q;
  assign halted    = (state_q == S_HALTED);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural instruction memory, IF/ID scoreboard,
// and point checks on the request interface, halt and error flags.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPC;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemReady;
  logic [15:0] imemData;
  logic [15:0] instr;
  logic [15:0] PC;
  logic        valid;
  logic        halted;
  logic        err;
  logic [2:0]  dbg_state;

  int checks;
  int failures;
  logic [32:0] exp_q[$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
    .instr(instr), .PC(PC), .valid(valid), .halted(halted), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem(input logic [15:0] a);
    logic [15:0] r;
    r = 16'h4000 + a;
    if (a == 16'h000A) r = 16'h0000;
    return r;
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // one clock: drive inputs, answer the memory, then score any expected IF/ID load
  task automatic cyc(input logic rdy, input logic stl, input logic rd, input logic [15:0] rpc);
    logic [32:0] e;
    imemReady  = rdy;
    stall      = stl;
    redirect   = rd;
    redirectPC = rpc;
    imemData   = mem(imemAddr);
    @(posedge clk);
    #1;
    imemReady = 1'b0;
    redirect  = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ifid", {valid, instr, PC}, e);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [15:0] addr);
    check({tag, "_req"}, {32'd0, imemReq}, {32'd0, req});
    if (req) check({tag, "_addr"}, {17'd0, imemAddr}, {17'd0, addr});
  endtask

  task automatic chk_bubble(input string tag);
    check(tag, {16'd0, valid, instr}, {16'd0, 1'b0, 16'h0800});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirectPC = 16'h0000;
    imemReady = 1'b0;
    imemData = 16'h0000;
    #12;
    check("rst_ifid", {valid, instr, PC}, {1'b0, 16'h0800, 16'h0000});
    check("rst_flags", {29'd0, halted, err, 2'b00}, 33'd0);
    check("rst_state", {30'd0, dbg_state}, 33'd0);
    chk_req("rst", 1'b1, 16'h0000);
    rst = 1'b0;

    // memory slow for addr 0: request held, nothing valid
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0);
      chk_req("wait0", 1'b1, 16'h0000);
      check("wait0_valid", {32'd0, valid}, 33'd0);
    end
    exp_q.push_back({1'b1, 16'h4000, 16'h0002});
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    exp_q.push_back({1'b1, 16'h4002, 16'h0004});
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk_req("stream", 1'b1, 16'h0004);

    // response for 0004 lands in the skid while decode is stalled
    exp_q.push_back({1'b1, 16'h4002, 16'h0004});
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk_req("hold1", 1'b0, 16'h0);
    exp_q.push_back({1'b1, 16'h4002, 16'h0004});
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    chk_req("hold2", 1'b0, 16'h0);
    exp_q.push_back({1'b1, 16'h4004, 16'h0006});
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk_req("unstall", 1'b1, 16'h0006);
    exp_q.push_back({1'b1, 16'h4006, 16'h0008});
    cyc(1'b1, 1'b0, 1'b0, 16'h0);

    // redirect while waiting on 0008; late response must be dropped
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk_req("wait8", 1'b1, 16'h0008);
    chk_bubble("wait8_bubble");
    cyc(1'b0, 1'b0, 1'b1, 16'h0100);
    chk_bubble("redir_flush");
    chk_req("discard1", 1'b0, 16'h0);
    check("discard_state", {30'd0, dbg_state}, 33'd3);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk_req("discard2", 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk_bubble("dropped");
    chk_req("after_drop", 1'b1, 16'h0100);
    exp_q.push_back({1'b1, 16'h4100, 16'h0102});
    cyc(1'b1, 1'b0, 1'b0, 16'h0);

    // redirect with a same-cycle response, then HALT fetched at 000A
    cyc(1'b1, 1'b0, 1'b1, 16'h000A);
    chk_bubble("same_cycle_drop");
    chk_req("to_halt", 1'b1, 16'h000A);
    exp_q.push_back({1'b1, 16'h0000, 16'h000C});
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    check("halted_set", {32'd0, halted}, 33'd1);
    chk_req("halted_req", 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk_bubble("halt_drain");
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    check("halted_stays", {31'd0, halted, imemReq}, {31'd0, 1'b1, 1'b0});
    cyc(1'b0, 1'b0, 1'b1, 16'h0020);
    check("halted_clr", {32'd0, halted}, 33'd0);
    chk_req("resume", 1'b1, 16'h0020);
    exp_q.push_back({1'b1, 16'h4020, 16'h0022});
    cyc(1'b1, 1'b0, 1'b0, 16'h0);

    // PC wrap at the top of the address space
    cyc(1'b1, 1'b0, 1'b1, 16'hFFFE);
    chk_req("wrap_pre", 1'b1, 16'hFFFE);
    exp_q.push_back({1'b1, 16'h3FFE, 16'h0000});
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk_req("wrap_post", 1'b1, 16'h0000);
    check("err_clear", {32'd0, err}, 33'd0);

    // misaligned redirect: err sticky, pcReg still loaded
    cyc(1'b0, 1'b0, 1'b1, 16'h0031);
    check("err_set", {32'd0, err}, 33'd1);
    chk_req("mis_discard", 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk_req("mis_fetch", 1'b1, 16'h0031);
    cyc(1'b1, 1'b0, 1'b1, 16'h0040);
    check("err_sticky", {32'd0, err}, 33'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk_req("pre_rst_wait", 1'b1, 16'h0040);

    // asynchronous reset mid-WAIT
    #2;
    rst = 1'b1;
    #1;
    check("arst_ifid", {valid, instr, PC}, {1'b0, 16'h0800, 16'h0000});
    check("arst_flags", {31'd0, halted, err}, 33'd0);
    chk_req("arst", 1'b1, 16'h0000);
    #2;
    rst = 1'b0;
    check("queue_drained", {1'b0, 32'(exp_q.size())}, 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
